mem_req_master: RTL
===================

Name: mem_req_master

Overview:
- Initiator side of the memory bus: the single master that drives mem_in_bus_t into mem_sys and collects data_out.
- Accepts one CPU memory operation at a time over a valid/ready request port: array read, array write, allocate, or load-program.
- Drives exactly one bus cycle per operation, then idles the bus.
- Returns exactly one response per operation over a valid/ready response port.

Parameters:
- DATA_W, 32, width of address, offset, data and response fields.
- READ_LAT, 1, cycles from the bus-drive edge until mem_sys data_out is valid (≥1).

Ports:
- clk  input  1  system clock, rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- req_valid  input  1  request offered.
- req_ready  output  1  master can accept a request.
- req_op  input  2  0=READ, 1=WRITE, 2=ALLOC, 3=LOADPROG.
- req_addr  input  DATA_W  array address; 0 selects the program (zero) array.
- req_offset  input  DATA_W  word offset (READ/WRITE) or allocation size in words (ALLOC).
- req_data  input  DATA_W  write data (WRITE) or new zero-array base (LOADPROG).
- rsp_valid  output  1  response available.
- rsp_ready  input  1  consumer takes the response.
- rsp_data  output  DATA_W  read word (READ), allocated base (ALLOC), 0 otherwise.
- mem_bus  output  mem_in_bus_t  {address, offset, data, mode} to mem_sys.
- bus_en  output  1  enable for mem_in_bus_buf; 1 only while driving.
- mem_data  input  DATA_W  mem_sys data_out.
- busy  output  1  state != IDLE.

Behaviour:
- Reset is asynchronous on the falling edge of reset_n. It forces, with no clock:
  - state=IDLE, rsp_valid=0, rsp_data=0, bus_en=0.
  - mem_bus idle value: address=0, offset=0, data=0, mode=READ (3'b000).
  - An in-flight operation is dropped with no response.
- The idle bus value is a harmless read. mem_sys executes the bus mode on every clock, so WRITE/ALLOC/LOADPROG mode must appear for exactly one cycle; a second cycle would double-write or double-allocate.
- op to mode mapping: READ→00, WRITE→01, ALLOC→10, LOADPROG→11. Mode upper bit is always 0.
- FSM states:
  - IDLE: req_ready=1. On req_valid, latch op/addr/offset/data, go to DRIVE.
  - DRIVE: exactly 1 cycle. mem_bus = latched request, bus_en=1. Next state is WAIT.
  - WAIT: count READ_LAT cycles. Bus idle, bus_en=0. On the last WAIT cycle, register rsp_data:
    - mem_data for READ/ALLOC;
    - 0 for WRITE/LOADPROG.
    Then go to RESP.
  - RESP: rsp_valid=1 with rsp_data stable. Go to IDLE on rsp_ready.
- Timing: accept at edge ending cycle T. DRIVE in T+1. rsp_valid first high in cycle T+2+READ_LAT.
- req_ready is 0 in every state except IDLE. A request offered during RESP waits; it is never lost and never merged.
- Operation counter, DATA_W bits: increments on each DRIVE and wraps at 2^DATA_W to 0. Debug only, not a port.
- WRITE/LOADPROG responses are completion tokens only. Strict in-order, one outstanding op.
- ALLOC with req_offset=0 is still issued. It returns the current allocation pointer.
- req_* may change freely after acceptance; the latched copy is used.
- rsp_ready held low: RESP holds indefinitely; the bus stays idle.
- Reset asserted in WAIT/RESP: response is lost and rsp_valid drops immediately. After release, the first op behaves as from power-up.

Decomposition:
- BusTypes package gains:
  - mem_op_t enum (READ, WRITE, ALLOC, LOADPROG);
  - mem_mode constants MODE_READ/WRITE/ALLOC/ZERO;
  - MEM_BUS_IDLE constant of mem_in_bus_t;
  - mem_state_t for the FSM.
- One natural sub-module: mem_rsp_reg, a single-entry response holding register with valid/ready. Everything else is inline.

Test Plan:
- Reset then idle: reset_n low 3 cycles, release → bus_en=0, mode=000, req_ready=1, rsp_valid=0; mem_sys contents unchanged over 20 idle cycles.
- Write then read: WRITE addr=0x40 off=3 data=0xDEADBEEF, then READ addr=0x40 off=3 → WRITE response rsp_data=0; READ rsp_data=0xDEADBEEF; READ rsp_valid at T+3 with READ_LAT=1.
- Single-cycle mode: ALLOC off=16 twice from next_alloc=0x100 → rsp_data 0x100 then 0x110; mode=10 observed exactly one cycle per op.
- LOADPROG data=0x2000, then READ addr=0 off=1 → bus carries mode 11/data 0x2000 for one cycle; read returns mem[0x2001].
- Backpressure: hold rsp_ready=0 for 10 cycles with req_valid=1 → rsp_valid and rsp_data stable, req_ready=0, bus idle; release → next op accepted the cycle after the handshake.
- Reset mid-op: assert reset_n=0 during WAIT of a READ → rsp_valid=0 and bus idle within the same cycle; no response after release; the next WRITE completes normally.

Source files
------------

// File: rtl/mem_req_master_pkg.sv
// Shared bus payload, opcode/mode encodings and FSM state type for the memory
// request master and its sub-modules.
package mem_req_master_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned MODE_W = 3;

    // CPU-side operation codes carried on req_op.
    typedef enum logic [1:0] {
        OP_READ     = 2'd0,
        OP_WRITE    = 2'd1,
        OP_ALLOC    = 2'd2,
        OP_LOADPROG = 2'd3
    } mem_op_t;

    // mem_sys bus modes; the upper bit is never set by this master.
    localparam logic [MODE_W-1:0] MODE_READ  = 3'b000;
    localparam logic [MODE_W-1:0] MODE_WRITE = 3'b001;
    localparam logic [MODE_W-1:0] MODE_ALLOC = 3'b010;
    localparam logic [MODE_W-1:0] MODE_ZERO  = 3'b011;

    typedef struct packed {
        logic [DATA_W-1:0] address;
        logic [DATA_W-1:0] offset;
        logic [DATA_W-1:0] data;
        logic [MODE_W-1:0] mode;
    } mem_in_bus_t;

    // Idle bus is a harmless read of array 0, offset 0.
    localparam mem_in_bus_t MEM_BUS_IDLE = '{
        address: '0,
        offset:  '0,
        data:    '0,
        mode:    MODE_READ
    };

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } mem_state_t;

    function automatic logic [MODE_W-1:0] op_to_mode(input mem_op_t op);
        logic [MODE_W-1:0] mode;
        case (op)
            OP_READ:     mode = MODE_READ;
            OP_WRITE:    mode = MODE_WRITE;
            OP_ALLOC:    mode = MODE_ALLOC;
            OP_LOADPROG: mode = MODE_ZERO;
            default:     mode = MODE_READ;
        endcase
        return mode;
    endfunction

    // READ and ALLOC return mem_sys data; WRITE and LOADPROG return a zero token.
    function automatic logic op_returns_data(input mem_op_t op);
        return (op == OP_READ) || (op == OP_ALLOC);
    endfunction

endpackage

// File: rtl/mem_req_master_rsp.sv
// Single-entry response holding register with valid/ready handshake.
// Ports:
//   clk, reset_n           clock, async active-low reset
//   load, load_data        capture a new response (only when empty)
//   rsp_valid, rsp_data    held response, registered
//   rsp_ready              consumer accepts the held response
module mem_rsp_reg
    import mem_req_master_pkg::*;
(
    input  logic              clk,
    input  logic              reset_n,
    input  logic              load,
    input  logic [DATA_W-1:0] load_data,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data
);

    // Data is held stable while valid; it is only replaced on a new load.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
        end else if (load) begin
            rsp_valid <= 1'b1;
            rsp_data  <= load_data;
        end else if (rsp_valid && rsp_ready) begin
            rsp_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/mem_req_master.sv
// Memory bus initiator: accepts one CPU operation at a time, drives exactly one
// mem_sys bus cycle for it, waits READ_LAT cycles and returns one response.
// Ports:
//   clk, reset_n                         clock, async active-low reset
//   req_valid/req_ready/req_op/req_addr/req_offset/req_data   request port
//   rsp_valid/rsp_ready/rsp_data         response port
//   mem_bus, bus_en                      bus to mem_sys and its buffer enable
//   mem_data                             mem_sys data_out
//   busy                                 FSM not idle
module mem_req_master
    import mem_req_master_pkg::*;
#(
    parameter int unsigned READ_LAT = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [1:0]        req_op,
    input  logic [DATA_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_offset,
    input  logic [DATA_W-1:0] req_data,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output mem_in_bus_t       mem_bus,
    output logic              bus_en,
    input  logic [DATA_W-1:0] mem_data,
    output logic              busy
);

    localparam int unsigned CNT_W = $clog2(READ_LAT + 1);
    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(READ_LAT - 1);

    mem_state_t        state_q, state_d;
    mem_op_t           op_q, op_d;
    logic [CNT_W-1:0]  wait_cnt_q, wait_cnt_d;
    logic [DATA_W-1:0] op_cnt_q, op_cnt_d;
    mem_in_bus_t       mem_bus_d;
    logic              bus_en_d;
    logic              req_ready_d;
    logic              busy_d;
    logic              rsp_load_c;
    logic [DATA_W-1:0] rsp_load_data_c;

    // State and registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            op_q       <= OP_READ;
            wait_cnt_q <= '0;
            op_cnt_q   <= '0;
            mem_bus    <= MEM_BUS_IDLE;
            bus_en     <= 1'b0;
            req_ready  <= 1'b1;
            busy       <= 1'b0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            wait_cnt_q <= wait_cnt_d;
            op_cnt_q   <= op_cnt_d;
            mem_bus    <= mem_bus_d;
            bus_en     <= bus_en_d;
            req_ready  <= req_ready_d;
            busy       <= busy_d;
        end
    end

    // Next state; bus payload is computed on acceptance so it appears for
    // exactly the DRIVE cycle and reverts to the idle read afterwards.
    always_comb begin
        state_d         = state_q;
        op_d            = op_q;
        wait_cnt_d      = wait_cnt_q;
        op_cnt_d        = op_cnt_q;
        mem_bus_d       = MEM_BUS_IDLE;
        bus_en_d        = 1'b0;
        rsp_load_c      = 1'b0;
        rsp_load_data_c = '0;

        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    op_d              = mem_op_t'(req_op);
                    mem_bus_d.address = req_addr;
                    mem_bus_d.offset  = req_offset;
                    mem_bus_d.data    = req_data;
                    mem_bus_d.mode    = op_to_mode(mem_op_t'(req_op));
                    bus_en_d          = 1'b1;
                    state_d           = ST_DRIVE;
                end
            end
            ST_DRIVE: begin
                op_cnt_d   = op_cnt_q + DATA_W'(1);
                wait_cnt_d = '0;
                state_d    = ST_WAIT;
            end
            ST_WAIT: begin
                if (wait_cnt_q == WAIT_LAST) begin
                    rsp_load_c      = 1'b1;
                    rsp_load_data_c = op_returns_data(op_q) ? mem_data : '0;
                    state_d         = ST_RESP;
                end else begin
                    wait_cnt_d = wait_cnt_q + CNT_W'(1);
                end
            end
            ST_RESP: begin
                if (rsp_valid && rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        req_ready_d = (state_d == ST_IDLE);
        busy_d      = (state_d != ST_IDLE);
    end

    mem_rsp_reg u_rsp_reg (
        .clk       (clk),
        .reset_n   (reset_n),
        .load      (rsp_load_c),
        .load_data (rsp_load_data_c),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data)
    );

endmodule
